// File: rtl/cam_pipe_if.sv
// rtl/cam_pipe_if.sv - write/invalidate/flush, search request/result and allocation status bundle for cam_pipe
interface cam_pipe_if #(
  parameter int KEY_W  = 8,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [KEY_W-1:0]  wr_key;
  logic              inv_en;
  logic [ADDR_W-1:0] inv_addr;
  logic              flush;
  logic              srch_valid;
  logic [KEY_W-1:0]  srch_key;
  logic              res_valid;
  logic              hit;
  logic [ADDR_W-1:0] hit_addr;
  logic              multi_hit;
  logic              full;
  logic [ADDR_W-1:0] free_addr;
  logic [ADDR_W:0]   count;

  modport master (
    output wr_en, wr_addr, wr_key, inv_en, inv_addr, flush, srch_valid, srch_key,
    input  res_valid, hit, hit_addr, multi_hit, full, free_addr, count
  );

  modport slave (
    input  wr_en, wr_addr, wr_key, inv_en, inv_addr, flush, srch_valid, srch_key,
    output res_valid, hit, hit_addr, multi_hit, full, free_addr, count
  );
endinterface

// File: rtl/cam_pipe.sv
// rtl/cam_pipe.sv - CAM with valid bits, invalidate/flush, 2-stage pipelined search and free-slot tracking
module cam_pipe #(
  parameter  int KEY_W  = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  cam_pipe_if.slave  bus
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [KEY_W-1:0]  key_q [DEPTH];
  logic [KEY_W-1:0]  key_d [DEPTH];

  logic [DEPTH-1:0]  match_q, match_d;
  logic              s1_valid_q, s1_valid_d;

  logic              res_valid_q, res_valid_d;
  logic              hit_q, hit_d;
  logic [ADDR_W-1:0] hit_addr_q, hit_addr_d;
  logic              multi_hit_q, multi_hit_d;

  logic              full_q, full_d;
  logic [ADDR_W-1:0] free_addr_q, free_addr_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic [ADDR_W-1:0] match_enc;
  logic [ADDR_W:0]   match_cnt;

  // Entry update: flush beats write, write beats invalidate on the same entry.
  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.flush) begin
        valid_d[i] = 1'b0;
      end else if (bus.wr_en && (bus.wr_addr == ADDR_W'(i))) begin
        valid_d[i] = 1'b1;
        key_d[i]   = bus.wr_key;
      end else if (bus.inv_en && (bus.inv_addr == ADDR_W'(i))) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  // Stage 1 compares against pre-edge contents so same-cycle writes are not seen.
  always_comb begin
    s1_valid_d = bus.srch_valid;
    match_d    = match_q;
    if (bus.srch_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        match_d[i] = valid_q[i] && (key_q[i] == bus.srch_key);
      end
    end
  end

  always_comb begin
    match_enc = '0;
    match_cnt = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_q[i]) begin
        match_enc = ADDR_W'(i);
      end
      match_cnt = match_cnt + (ADDR_W+1)'(match_q[i]);
    end
  end

  always_comb begin
    res_valid_d = s1_valid_q;
    hit_d       = hit_q;
    hit_addr_d  = hit_addr_q;
    multi_hit_d = multi_hit_q;
    if (s1_valid_q) begin
      hit_d       = |match_q;
      hit_addr_d  = match_enc;
      multi_hit_d = (match_cnt >= (ADDR_W+1)'(2));
    end
  end

  // Allocation status tracks the post-edge valid bits, so it is built from valid_d.
  always_comb begin
    count_d     = '0;
    free_addr_d = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_d[i]) begin
        free_addr_d = ADDR_W'(i);
      end
      count_d = count_d + (ADDR_W+1)'(valid_d[i]);
    end
    full_d = &valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i] <= '0;
      end
      match_q     <= '0;
      s1_valid_q  <= 1'b0;
      res_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      hit_addr_q  <= '0;
      multi_hit_q <= 1'b0;
      full_q      <= 1'b0;
      free_addr_q <= '0;
      count_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      key_q       <= key_d;
      match_q     <= match_d;
      s1_valid_q  <= s1_valid_d;
      res_valid_q <= res_valid_d;
      hit_q       <= hit_d;
      hit_addr_q  <= hit_addr_d;
      multi_hit_q <= multi_hit_d;
      full_q      <= full_d;
      free_addr_q <= free_addr_d;
      count_q     <= count_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.hit       = hit_q;
  assign bus.hit_addr  = hit_addr_q;
  assign bus.multi_hit = multi_hit_q;
  assign bus.full      = full_q;
  assign bus.free_addr = free_addr_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_cam_pipe.sv
// tb/tb_cam_pipe.sv - scoreboard bench for cam_pipe
module tb_cam_pipe;

  localparam int KEY_W  = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  typedef struct packed {
    logic              hit;
    logic [ADDR_W-1:0] addr;
    logic              multi;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  exp_t             sb[$];
  logic             mval [DEPTH];
  logic [KEY_W-1:0] mkey [DEPTH];

  cam_pipe_if #(.KEY_W(KEY_W), .ADDR_W(ADDR_W)) bus ();

  cam_pipe #(.KEY_W(KEY_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.res_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_res", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hit", 32'(bus.hit), 32'(e.hit));
        chk("hit_addr", 32'(bus.hit_addr), 32'(e.addr));
        chk("multi_hit", 32'(bus.multi_hit), 32'(e.multi));
      end
    end
  end

  task automatic clr_inputs();
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_key     = '0;
    bus.inv_en     = 1'b0;
    bus.inv_addr   = '0;
    bus.flush      = 1'b0;
    bus.srch_valid = 1'b0;
    bus.srch_key   = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mval[i] = 1'b0;
      mkey[i] = '0;
    end
  endtask

  task automatic set_wr(input int a, input logic [KEY_W-1:0] k);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(a);
    bus.wr_key  = k;
  endtask

  task automatic set_inv(input int a);
    bus.inv_en   = 1'b1;
    bus.inv_addr = ADDR_W'(a);
  endtask

  task automatic set_srch(input logic [KEY_W-1:0] k);
    bus.srch_valid = 1'b1;
    bus.srch_key   = k;
  endtask

  // One clock: push the expected search result from pre-edge model, update model, check status.
  task automatic tick();
    exp_t e;
    int   n;
    int   cnt;
    int   fr;
    if (bus.srch_valid) begin
      e = '0;
      n = 0;
      for (int i = 0; i < DEPTH; i++) begin
        if (mval[i] && mkey[i] == bus.srch_key) begin
          if (!e.hit) e.addr = ADDR_W'(i);
          e.hit = 1'b1;
          n++;
        end
      end
      e.multi = (n >= 2);
      sb.push_back(e);
    end
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) mval[i] = 1'b0;
    end else begin
      if (bus.inv_en) mval[bus.inv_addr] = 1'b0;
      if (bus.wr_en) begin
        mval[bus.wr_addr] = 1'b1;
        mkey[bus.wr_addr] = bus.wr_key;
      end
    end
    @(posedge clk);
    #1;
    clr_inputs();
    cnt = 0;
    fr  = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (mval[i]) cnt++;
      else if (fr < 0) fr = i;
    end
    if (fr < 0) fr = 0;
    chk("count_model", 32'(bus.count), 32'(cnt));
    chk("full_model", 32'(bus.full), 32'(cnt == DEPTH));
    chk("free_model", 32'(bus.free_addr), 32'(fr));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clr_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_hit", 32'(bus.hit), 32'd0);
    chk("rst_hit_addr", 32'(bus.hit_addr), 32'd0);
    chk("rst_multi", 32'(bus.multi_hit), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_free", 32'(bus.free_addr), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    @(posedge clk);
    #1;

    // Empty CAM search
    set_srch(8'hAA); tick();
    tick(); tick();

    // Basic writes and back-to-back searches
    set_wr(0, 8'hAA); tick();
    set_wr(1, 8'h55); tick();
    set_srch(8'hAA); tick();
    set_srch(8'h55); tick();
    set_srch(8'hFF); tick();
    tick(); tick();
    chk("tp2_count", 32'(bus.count), 32'd2);
    chk("tp2_free", 32'(bus.free_addr), 32'd2);

    // Duplicate keys and invalidate
    set_wr(2, 8'h3C); tick();
    set_wr(5, 8'h3C); tick();
    set_srch(8'h3C); tick();
    set_inv(2); tick();
    set_srch(8'h3C); tick();
    tick(); tick();
    chk("hold_res_valid", 32'(bus.res_valid), 32'd0);
    chk("hold_hit", 32'(bus.hit), 32'd1);
    chk("hold_hit_addr", 32'(bus.hit_addr), 32'd5);

    // Search sees pre-edge contents when written in same cycle
    set_srch(8'hAA); set_wr(3, 8'hAA); tick();
    set_srch(8'hAA); tick();
    tick(); tick();

    // Fill, then flush with a concurrent write
    set_wr(2, 8'h10); tick();
    set_wr(4, 8'h11); tick();
    set_wr(6, 8'h12); tick();
    set_wr(7, 8'h13); tick();
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd8);
    chk("fill_free", 32'(bus.free_addr), 32'd0);
    set_wr(0, 8'h99); bus.flush = 1'b1; tick();
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_full", 32'(bus.full), 32'd0);
    chk("flush_free", 32'(bus.free_addr), 32'd0);
    set_srch(8'h99); tick();
    set_srch(8'h12); tick();
    tick(); tick();

    // Write wins over invalidate on same address; different addresses both apply
    set_wr(4, 8'h77); set_inv(4); tick();
    set_srch(8'h77); tick();
    set_wr(6, 8'h66); set_inv(4); tick();
    set_srch(8'h77); tick();
    set_srch(8'h66); tick();
    tick(); tick();
    chk("wrinv_count", 32'(bus.count), 32'd1);

    // Reset with a search sitting in stage 1
    set_srch(8'h66);
    @(posedge clk);
    #1;
    clr_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("midrst_count", 32'(bus.count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("postrst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
